// File: rtl/i2s_rx.sv
// I2S capture: deserialises stereo PCM from oversampled bit_clk/frame_clk/sdata into left/right pairs.
// Latency: sample_valid rises one clk after the synchronised bit_clk rise that closes the right word.
// Backpressure: a pair is held until accepted; a new pair arriving while held is dropped and overrun set.
module i2s_rx #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_clk,
    input  logic                    frame_clk,
    input  logic                    sdata,
    input  logic                    sample_ready,
    input  logic                    clr_overrun,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    overrun,
    output logic                    locked
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WORD_BITS = CW'(SAMPLE_WIDTH);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  ws_sync;
    logic [SYNC_STAGES-1:0]  sd_sync;
    logic                    bclk_d;
    logic                    bclk_s;
    logic                    ws_s;
    logic                    sd_s;
    logic                    bclk_rise;

    logic                    ws_prev;
    logic                    ws_change;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [CW-1:0]           count;
    logic [SAMPLE_WIDTH-1:0] shreg_shift;
    logic [CW-1:0]           count_shift;
    logic [CW-1:0]           pad;
    logic [SAMPLE_WIDTH-1:0] word;

    logic [SAMPLE_WIDTH-1:0] left_hold;
    logic                    left_seen;
    logic [TW-1:0]           to_cnt;
    logic                    timeout_hit;

    logic                    commit_left;
    logic                    commit_right;
    logic                    emit_pair;
    logic                    out_room;
    logic                    accept;

    // Every codec input gets the same depth so bit, word select and data stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            bclk_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bit_clk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], frame_clk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdata};
            bclk_d    <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign ws_s      = ws_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_d;
    assign ws_change = bclk_rise && (ws_s != ws_prev);

    // Bits beyond the word width are ignored; short slots are left-justified on commit.
    always_comb begin
        shreg_shift = shreg;
        count_shift = count;
        if (count < WORD_BITS) begin
            shreg_shift = {shreg[SAMPLE_WIDTH-2:0], sd_s};
            count_shift = count + CW'(1);
        end
        pad  = WORD_BITS - count_shift;
        word = shreg_shift << pad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        commit_left  = 1'b0;
        commit_right = 1'b0;
        timeout_hit  = (state == RUN) && (to_cnt == TO_MAX);
        case (state)
            HUNT: begin
                if (ws_change) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (timeout_hit) begin
                    state_nxt = HUNT;
                end else if (ws_change) begin
                    if (!ws_prev) begin
                        commit_left = 1'b1;
                    end else begin
                        commit_right = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    assign emit_pair = commit_right && left_seen;
    assign accept    = sample_valid && sample_ready;
    assign out_room  = !sample_valid || sample_ready;
    assign locked    = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_prev   <= 1'b0;
            shreg     <= '0;
            count     <= '0;
            left_hold <= '0;
            left_seen <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (bclk_rise) begin
                ws_prev <= ws_s;
                to_cnt  <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (timeout_hit) begin
                shreg     <= '0;
                count     <= '0;
                left_seen <= 1'b0;
            end else if (bclk_rise) begin
                if (ws_change) begin
                    shreg <= '0;
                    count <= '0;
                end else begin
                    shreg <= shreg_shift;
                    count <= count_shift;
                end
                if (commit_left) begin
                    left_hold <= word;
                    left_seen <= 1'b1;
                end else if (commit_right) begin
                    left_seen <= 1'b0;
                end
            end
        end
    end

    // Emit and accept in the same cycle reload the output without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (emit_pair && out_room) begin
                left_sample  <= left_hold;
                right_sample <= word;
                sample_valid <= 1'b1;
            end else if (accept) begin
                sample_valid <= 1'b0;
            end

            if (emit_pair && !out_room) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit-level I2S stimulus with one-bit word-select delay, 16 clk per bit.
module tb_i2s_rx;

    logic        clk;
    logic        reset;
    logic        bit_clk;
    logic        frame_clk;
    logic        sdata;
    logic        sample_ready;
    logic        clr_overrun;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        overrun;
    logic        locked;

    int   vectors;
    int   miscompares;
    logic carry;
    logic primed;

    i2s_rx #(
        .SAMPLE_WIDTH  (16),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_clk     (bit_clk),
        .frame_clk   (frame_clk),
        .sdata       (sdata),
        .sample_ready(sample_ready),
        .clr_overrun (clr_overrun),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .overrun     (overrun),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bit period: word select and data change while bit_clk is low.
    task automatic send_bit(input logic w, input logic b);
        @(negedge clk);
        bit_clk   = 1'b0;
        frame_clk = w;
        sdata     = b;
        repeat (8) @(negedge clk);
        bit_clk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // First bit of a slot carries the previous slot's last data bit (I2S one-bit delay).
    task automatic send_slot(input logic w, input logic [31:0] word, input int nbits, input int slot);
        int   k0;
        logic b;
        k0 = primed ? 1 : 0;
        for (int k = k0; k < slot; k++) begin
            if (k == 0) b = carry;
            else if (k - 1 < nbits) b = word[nbits-k];
            else b = 1'b0;
            send_bit(w, b);
        end
        carry  = (slot - 1 < nbits) ? word[nbits-slot] : 1'b0;
        primed = 1'b0;
    endtask

    task automatic close_pair();
        send_bit(1'b0, carry);
        primed = 1'b1;
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int nbits, input int slot);
        send_slot(1'b0, l, nbits, slot);
        send_slot(1'b1, r, nbits, slot);
        close_pair();
    endtask

    task automatic accept_one();
        @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        carry        = 1'b0;
        primed       = 1'b0;
        reset        = 1'b0;
        bit_clk      = 1'b0;
        frame_clk    = 1'b0;
        sdata        = 1'b0;
        sample_ready = 1'b0;
        clr_overrun  = 1'b0;
        #1;
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_left", 32'(left_sample), 32'h0);
        chk("rst_right", 32'(right_sample), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        repeat (4) @(negedge clk);
        reset = 1'b1;

        // Lock on a 0->1 edge; that right slot and the following right commit are discarded.
        send_slot(1'b1, 32'h0, 16, 32);
        chk("s1_locked", 32'(locked), 32'h1);
        send_slot(1'b0, 32'hA5C3, 16, 32);
        send_slot(1'b1, 32'h1234, 16, 32);
        chk("s1_no_early_valid", 32'(sample_valid), 32'h0);
        close_pair();
        chk("s1_valid", 32'(sample_valid), 32'h1);
        chk("s1_left", 32'(left_sample), 32'hA5C3);
        chk("s1_right", 32'(right_sample), 32'h1234);
        @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("s1_valid_drop", 32'(sample_valid), 32'h0);

        // Short 8-bit slots are left-justified.
        send_pair(32'hAB, 32'hCD, 8, 8);
        chk("s2_valid", 32'(sample_valid), 32'h1);
        chk("s2_left", 32'(left_sample), 32'hAB00);
        chk("s2_right", 32'(right_sample), 32'hCD00);
        accept_one();
        chk("s2_valid_drop", 32'(sample_valid), 32'h0);

        // Backpressure: second pair dropped, overrun sticky until cleared.
        send_pair(32'h1111, 32'h2222, 16, 32);
        chk("s3_valid", 32'(sample_valid), 32'h1);
        chk("s3_overrun_clear", 32'(overrun), 32'h0);
        send_pair(32'h3333, 32'h4444, 16, 32);
        chk("s3_left_kept", 32'(left_sample), 32'h1111);
        chk("s3_right_kept", 32'(right_sample), 32'h2222);
        chk("s3_overrun_set", 32'(overrun), 32'h1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("s3_overrun_cleared", 32'(overrun), 32'h0);

        // bit_clk stalls: link drops, pending pair survives until accepted.
        repeat (80) @(negedge clk);
        chk("s5_unlocked", 32'(locked), 32'h0);
        chk("s5_pending_valid", 32'(sample_valid), 32'h1);
        chk("s5_pending_left", 32'(left_sample), 32'h1111);
        accept_one();
        chk("s5_valid_drop", 32'(sample_valid), 32'h0);

        // Resume: relock on 0->1 edge, first right discarded, next full pair delivered.
        primed = 1'b0;
        send_slot(1'b1, 32'h5555, 16, 32);
        chk("s4_relocked", 32'(locked), 32'h1);
        send_slot(1'b0, 32'h0F0F, 16, 32);
        send_slot(1'b1, 32'hF0F0, 16, 32);
        chk("s4_no_early_valid", 32'(sample_valid), 32'h0);
        close_pair();
        chk("s4_valid", 32'(sample_valid), 32'h1);
        chk("s4_left", 32'(left_sample), 32'h0F0F);
        chk("s4_right", 32'(right_sample), 32'hF0F0);

        // Reset mid-left-word with a pending pair and overrun set.
        send_pair(32'h7777, 32'h8888, 16, 32);
        chk("s6_pre_overrun", 32'(overrun), 32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(sample_valid), 32'h0);
        chk("s6_rst_left", 32'(left_sample), 32'h0);
        chk("s6_rst_right", 32'(right_sample), 32'h0);
        chk("s6_rst_overrun", 32'(overrun), 32'h0);
        chk("s6_rst_locked", 32'(locked), 32'h0);
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        primed = 1'b0;
        carry  = 1'b0;
        send_slot(1'b1, 32'h0, 16, 32);
        send_pair(32'hA5C3, 32'h1234, 16, 32);
        chk("s6_valid", 32'(sample_valid), 32'h1);
        chk("s6_left", 32'(left_sample), 32'hA5C3);
        chk("s6_right", 32'(right_sample), 32'h1234);
        accept_one();
        chk("s6_valid_drop", 32'(sample_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
